// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM state codes and the default operand width.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Operation encodings as driven on the op port.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // FSM state codes.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// Single-iteration combinational datapath for the multiply/divide unit.
// Computes both candidate next accumulators from the current accumulator
// and the latched operand magnitudes; the caller selects one per operation.
//   acc        current 2*WIDTH accumulator
//   mcand      multiplicand magnitude (shift-add)
//   divisor    divisor magnitude (restoring division)
//   mul_acc_c  accumulator after one shift-add step
//   div_acc_c  accumulator after one trial-subtract-and-shift step
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] mul_acc_c,
    output logic [2*WIDTH-1:0] div_acc_c
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;

    // Shift-add: acc = {product_hi, multiplier_remaining}; add on LSB then shift right
    // keeping the carry so the upper half never overflows.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        mul_acc_c = {mul_sum, acc[WIDTH-1:1]};
    end

    // Restoring division: acc = {remainder, dividend_remaining/quotient}.
    // Partial remainder is the shifted remainder with the next dividend bit; the
    // trial subtraction's borrow bit decides whether it is kept.
    always_comb begin
        partial = acc[2*WIDTH-1:WIDTH-1];
        trial   = partial - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            div_acc_c = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_c = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One bit is resolved per cycle (WIDTH cycles in CALC) followed by a single
// FIX cycle that applies signs and commits HI/LO.
//   clk, rst_n   clock and asynchronous active-low reset
//   start, op    launch an operation (sampled only in IDLE)
//   operand_a/b  multiplicand/dividend and multiplier/divisor; operand_a is
//                also the MTHI/MTLO data
//   mthi, mtlo   direct writes of operand_a into HI/LO while idle
//   busy, done   operation in progress / one-cycle completion pulse
//   div_by_zero  divide with zero divisor, valid with done
//   hi, lo       HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, done_d;

    logic [1:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] a_mag_q, a_mag_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             dbz_d;

    logic             in_is_div_c, in_is_signed_c;
    logic             a_neg_c, b_neg_c;
    logic [WIDTH-1:0] a_abs_c, b_abs_c;
    logic             q_is_div_c, sign_diff_c, div_zero_c;
    logic [ACC_W-1:0] prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c, orig_a_c;
    logic [ACC_W-1:0] mul_acc_c, div_acc_c;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc_q),
        .mcand     (a_mag_q),
        .divisor   (b_mag_q),
        .mul_acc_c (mul_acc_c),
        .div_acc_c (div_acc_c)
    );

    // Operand decode at launch: magnitudes are only taken for signed ops.
    always_comb begin
        in_is_div_c    = (op == OP_DIVU) || (op == OP_DIV);
        in_is_signed_c = (op == OP_MULT) || (op == OP_DIV);
        a_neg_c        = in_is_signed_c & operand_a[WIDTH-1];
        b_neg_c        = in_is_signed_c & operand_b[WIDTH-1];
        a_abs_c        = a_neg_c ? -operand_a : operand_a;
        b_abs_c        = b_neg_c ? -operand_b : operand_b;
    end

    // Sign fix-up of the unsigned-magnitude result; sign flags are zero for
    // unsigned ops so no extra qualification is needed.
    always_comb begin
        q_is_div_c  = (op_q == OP_DIVU) || (op_q == OP_DIV);
        sign_diff_c = sign_a_q ^ sign_b_q;
        div_zero_c  = (b_mag_q == {WIDTH{1'b0}});
        prod_fix_c  = sign_diff_c ? -acc_q : acc_q;
        quo_fix_c   = sign_diff_c ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix_c   = sign_a_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];
        // Re-signing the dividend magnitude restores the original operand_a.
        orig_a_c    = sign_a_q ? -a_mag_q : a_mag_q;
    end

    // Next-state logic: IDLE -> CALC (WIDTH iterations) -> FIX -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    cnt_d   = CNT_W'(WIDTH - 1);
                end
            end
            ST_CALC: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Datapath next values: launch latch, iteration, commit, and MTHI/MTLO.
    always_comb begin
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        hi_d     = hi;
        lo_d     = lo;
        dbz_d    = div_by_zero;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = a_neg_c;
                    sign_b_d = b_neg_c;
                    a_mag_d  = a_abs_c;
                    b_mag_d  = b_abs_c;
                    acc_d    = in_is_div_c ? {{WIDTH{1'b0}}, a_abs_c}
                                           : {{WIDTH{1'b0}}, b_abs_c};
                    dbz_d    = 1'b0;
                end else begin
                    // Moves only when no operation is being launched.
                    if (mthi) hi_d = operand_a;
                    if (mtlo) lo_d = operand_a;
                end
            end
            ST_CALC: begin
                acc_d = q_is_div_c ? div_acc_c : mul_acc_c;
            end
            ST_FIX: begin
                if (!q_is_div_c) begin
                    hi_d  = prod_fix_c[ACC_W-1:WIDTH];
                    lo_d  = prod_fix_c[WIDTH-1:0];
                    dbz_d = 1'b0;
                end else if (div_zero_c) begin
                    hi_d  = orig_a_c;
                    lo_d  = {WIDTH{1'b1}};
                    dbz_d = 1'b1;
                end else begin
                    hi_d  = rem_fix_c;
                    lo_d  = quo_fix_c;
                    dbz_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            op_q        <= OP_MULTU;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            acc_q       <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy        <= busy_d;
            done        <= done_d;
            op_q        <= op_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            acc_q       <= acc_d;
            hi          <= hi_d;
            lo          <= lo_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit directly downstream of the register file in the execute stage.
- Takes the two register-file read operands and computes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle.
- Holds the 64-bit result in architectural HI/LO registers that later move-from instructions read.
- Also supports MTHI/MTLO direct writes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- operand_a  in  WIDTH  multiplicand/dividend; also MTHI/MTLO data. Driven from read_data1.
- operand_b  in  WIDTH  multiplier/divisor. Driven from read_data2.
- mthi  in  1  write operand_a into HI.
- mtlo  in  1  write operand_a into LO.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  valid with done; 1 if a DIV/DIVU had operand_b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0.
- Reset mid-operation aborts immediately, with no done pulse and no HI/LO update.
- FSM states:
  - IDLE.
  - CALC: WIDTH cycles, iteration counter WIDTH-1 down to 0.
  - FIX: 1 cycle.
- Transitions:
  - IDLE->CALC on start.
  - CALC->FIX when the counter reaches 0.
  - FIX->IDLE unconditionally.
- busy = (state != IDLE). It is high for exactly WIDTH+1 cycles.
- Latency: start sampled at edge E0. At edge E0+WIDTH+1:
  - state returns to IDLE;
  - hi/lo/div_by_zero update;
  - done=1 for that one cycle.
  - With WIDTH=32, this is 33 edges after start.
- At start, latch op, sign flags, and |operand_a|, |operand_b| into internal registers.
  - Absolute values are taken for signed ops only.
  - Operand changes after E0 have no effect.
- MULT/MULTU:
  - Shift-add over a 2*WIDTH accumulator.
  - FIX negates the 64-bit product when the signed operand signs differ.
  - {hi,lo} = product.
- DIV/DIVU:
  - Restoring division.
  - FIX applies signs: quotient negative when signs differ; remainder takes the dividend's sign.
  - lo = quotient, hi = remainder.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the unsigned-magnitude path with no special case.
- Divide by zero:
  - Full latency is kept.
  - lo = all ones, hi = original operand_a (unmodified), div_by_zero=1.
  - The same rule applies to signed and unsigned.
- div_by_zero is cleared on the next accepted start.
- hi/lo hold their previous values throughout CALC/FIX. No partial results are visible.
- start while busy is ignored, with no queueing.
- start in the same cycle that done is high is accepted (state is IDLE).
- MTHI/MTLO:
  - Act only in IDLE with start=0: the register takes operand_a at the next edge.
  - mthi and mtlo together write both registers.
  - Ignored while busy.
  - If start and mthi/mtlo are asserted together, start wins and the move is dropped.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV;
  - state enum IDLE/CALC/FIX;
  - default WIDTH constant.
- One natural sub-module: muldiv_step. It is a combinational single-iteration datapath that computes both options from {acc, operand regs}:
  - the shift-add step;
  - the restoring trial-subtract-and-shift step.
- The FSM and counter stay in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 edges: hi=0xFFFFFFFE, lo=0x00000001, done 1 cycle, busy high exactly 33 cycles.
- MULT 0xFFFFFFF9 (-7) × 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 10/5 -> lo=2, hi=0.
- DIVU 10/0 -> lo=0xFFFFFFFF, hi=0x0000000A, div_by_zero=1. A following DIVU 9/3 -> lo=3, hi=0, div_by_zero=0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Operands and start changed mid-operation (start=1 at cycle 5) -> result unaffected, no second done. Back-to-back start on the done cycle -> second result 33 edges later.
- mthi=1 with operand_a=0x1234 in IDLE -> hi=0x1234. mthi+start together -> hi unchanged until done. rst_n low at cycle 10 of a MULT -> busy=0, hi=lo=0, no done.
